// File: rtl/protected_access_guard.sv
// ---------------------------------------------------------------------------
// protected_access_guard
//
// Sits between the core load/store request port and the memory bus and
// enforces the write-protect boundary published by the protected_flag lock.
// Reads and permitted writes pass through a one-entry request register.
// Writes below protected_addr are acknowledged but not forwarded while the
// lock is active, and each one is recorded as a violation.
//
// Ports
//   clk              system clock, rising edge
//   nreset           synchronous active-low reset
//   protected_flag   lock active
//   protected_addr   protect boundary (writes strictly below it are blocked)
//   req_valid        core request valid
//   req_ready        guard can accept a request (IDLE only)
//   req_write        1 = write, 0 = read
//   req_addr         request address
//   req_wdata        request write data
//   mem_valid        forwarded request valid
//   mem_ready        memory accepts the forwarded request
//   mem_write        forwarded write enable
//   mem_addr         forwarded address
//   mem_wdata        forwarded write data
//   fault_clear      clears fault / fault_addr (violation_count is kept)
//   fault_pulse      one-cycle pulse per blocked write
//   fault            sticky flag: a write was blocked since the last clear
//   fault_addr       address of the first blocked write since the last clear
//   violation_count  blocked writes since reset, saturating
// ---------------------------------------------------------------------------
module protected_access_guard #(
   parameter int unsigned BUS_WIDTH = 32,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 protected_flag,
   input  logic [BUS_WIDTH-1:0] protected_addr,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [BUS_WIDTH-1:0] req_addr,
   input  logic [BUS_WIDTH-1:0] req_wdata,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic                 mem_write,
   output logic [BUS_WIDTH-1:0] mem_addr,
   output logic [BUS_WIDTH-1:0] mem_wdata,
   input  logic                 fault_clear,
   output logic                 fault_pulse,
   output logic                 fault,
   output logic [BUS_WIDTH-1:0] fault_addr,
   output logic [CNT_WIDTH-1:0] violation_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      BLOCK = 2'd2
   } state_t;

   // A write is blocked only while the lock is set and the address lies
   // strictly below the boundary (unsigned). A boundary of zero therefore
   // blocks nothing, and a write exactly at the boundary is allowed.
   function automatic logic is_protected_write(
      input logic                 flag,
      input logic [BUS_WIDTH-1:0] bound,
      input logic                 wr,
      input logic [BUS_WIDTH-1:0] addr
   );
      return wr & flag & (addr < bound);
   endfunction

   // Counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(
      input logic [CNT_WIDTH-1:0] v
   );
      logic [CNT_WIDTH-1:0] one;
      one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      return (&v) ? v : v + one;
   endfunction

   state_t               state_q, state_d;
   logic                 latch_en;
   logic                 prot_wr;

   // Request holding register (data only, no reset needed: every output
   // derived from it is gated by the state).
   logic                 wr_q;
   logic [BUS_WIDTH-1:0] addr_q;
   logic [BUS_WIDTH-1:0] wdata_q;

   logic                 fault_q, fault_d;
   logic [BUS_WIDTH-1:0] fault_addr_q, fault_addr_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   assign prot_wr = is_protected_write(protected_flag, protected_addr,
                                       req_write, req_addr);

   // Next-state logic. Flag and boundary are only looked at in the
   // handshake cycle, so later changes cannot affect a latched request.
   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               latch_en = 1'b1;
               state_d  = prot_wr ? BLOCK : FWD;
            end
         end
         FWD: begin
            if (mem_ready) begin
               state_d = IDLE;
            end
         end
         BLOCK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Fault bookkeeping. A BLOCK cycle takes priority over fault_clear:
   // the fault stays set and the new address replaces the old one.
   always_comb begin
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      cnt_d        = cnt_q;
      if (state_q == BLOCK) begin
         fault_d = 1'b1;
         cnt_d   = sat_inc(cnt_q);
         if (!fault_q || fault_clear) begin
            fault_addr_d = addr_q;
         end
      end else if (fault_clear) begin
         fault_d      = 1'b0;
         fault_addr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q      <= IDLE;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         cnt_q        <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (latch_en) begin
         wr_q    <= req_write;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   assign req_ready       = (state_q == IDLE);
   assign mem_valid       = (state_q == FWD);
   assign mem_write       = mem_valid & wr_q;
   assign mem_addr        = mem_valid ? addr_q  : '0;
   assign mem_wdata       = mem_valid ? wdata_q : '0;
   assign fault_pulse     = (state_q == BLOCK);
   assign fault           = fault_q;
   assign fault_addr      = fault_addr_q;
   assign violation_count = cnt_q;

endmodule

// File: tb/tb_protected_access_guard.sv
module tb_protected_access_guard;

   logic        clk;
   logic        nreset;
   logic        protected_flag;
   logic [31:0] protected_addr;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        fault_clear;
   logic        fault_pulse;
   logic        fault;
   logic [31:0] fault_addr;
   logic [7:0]  violation_count;

   // Second instance, narrow counter, same stimulus; only its outputs
   // relevant to saturation are checked.
   logic        req_ready2, mem_valid2, mem_write2, fault_pulse2, fault2;
   logic [31:0] mem_addr2, mem_wdata2, fault_addr2;
   logic [1:0]  violation_count2;

   protected_access_guard #(.BUS_WIDTH(32), .CNT_WIDTH(8)) dut (
      .clk(clk), .nreset(nreset),
      .protected_flag(protected_flag), .protected_addr(protected_addr),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .fault_clear(fault_clear), .fault_pulse(fault_pulse), .fault(fault),
      .fault_addr(fault_addr), .violation_count(violation_count)
   );

   protected_access_guard #(.BUS_WIDTH(32), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .nreset(nreset),
      .protected_flag(protected_flag), .protected_addr(protected_addr),
      .req_valid(req_valid), .req_ready(req_ready2), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_valid(mem_valid2), .mem_ready(mem_ready), .mem_write(mem_write2),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .fault_clear(fault_clear), .fault_pulse(fault_pulse2), .fault(fault2),
      .fault_addr(fault_addr2), .violation_count(violation_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state of the fault bookkeeping
   logic        fault_m;
   logic [31:0] faddr_m;
   int          cnt_m;
   int          cnt2_m;

   typedef struct {
      logic        flag;
      logic [31:0] paddr;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        fwd;     // 1 = forwarded, 0 = blocked
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_block(input logic [31:0] a, input logic clr);
      if (!fault_m || clr) faddr_m = a;
      fault_m = 1'b1;
      cnt_m   = (cnt_m  == 255) ? 255 : cnt_m + 1;
      cnt2_m  = (cnt2_m == 3)   ? 3   : cnt2_m + 1;
   endtask

   task automatic chk_fault_state(input string tag);
      chk({tag, ".fault"},      {31'd0, fault},          {31'd0, fault_m});
      chk({tag, ".fault_addr"}, fault_addr,              faddr_m);
      chk({tag, ".count"},      {24'd0, violation_count}, cnt_m[31:0]);
      chk({tag, ".count2"},     {30'd0, violation_count2}, cnt2_m[31:0]);
   endtask

   initial begin
      // flag, boundary, write, addr, wdata, forwarded
      vt[0]  = '{1'b0, 32'd3,          1'b1, 32'd1,          32'h1111_0001, 1'b1};
      vt[1]  = '{1'b1, 32'd3,          1'b1, 32'd2,          32'h2222_0002, 1'b0};
      vt[2]  = '{1'b1, 32'd3,          1'b1, 32'd3,          32'h3333_0003, 1'b1};
      vt[3]  = '{1'b1, 32'd3,          1'b0, 32'd0,          32'h4444_0004, 1'b1};
      vt[4]  = '{1'b1, 32'd3,          1'b1, 32'd1,          32'h5555_0005, 1'b0};
      vt[5]  = '{1'b1, 32'd0,          1'b1, 32'd0,          32'h6666_0006, 1'b1};
      vt[6]  = '{1'b0, 32'hFFFF_FFFF,  1'b1, 32'd5,          32'h7777_0007, 1'b1};
      vt[7]  = '{1'b1, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFE,  32'h8888_0008, 1'b0};
      vt[8]  = '{1'b1, 32'h8000_0000,  1'b1, 32'h7FFF_FFFF,  32'h9999_0009, 1'b0};
      vt[9]  = '{1'b1, 32'h0000_0010,  1'b1, 32'h8000_0000,  32'hAAAA_000A, 1'b1};
      vt[10] = '{1'b1, 32'hFFFF_FFFF,  1'b0, 32'd0,          32'hBBBB_000B, 1'b1};

      fault_m = 1'b0; faddr_m = '0; cnt_m = 0; cnt2_m = 0;

      nreset = 1'b0; protected_flag = 1'b0; protected_addr = '0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      mem_ready = 1'b1; fault_clear = 1'b0;

      // ---- reset state
      step(); step();
      chk("rst.req_ready",   {31'd0, req_ready},   32'd1);
      chk("rst.mem_valid",   {31'd0, mem_valid},   32'd0);
      chk("rst.mem_write",   {31'd0, mem_write},   32'd0);
      chk("rst.mem_addr",    mem_addr,             32'd0);
      chk("rst.mem_wdata",   mem_wdata,            32'd0);
      chk("rst.fault_pulse", {31'd0, fault_pulse}, 32'd0);
      chk_fault_state("rst");
      nreset = 1'b1;
      step();
      chk("rst1.req_ready", {31'd0, req_ready}, 32'd1);

      // ---- table-driven single transactions
      for (int i = 0; i < 11; i++) begin
         protected_flag = vt[i].flag;
         protected_addr = vt[i].paddr;
         req_write      = vt[i].wr;
         req_addr       = vt[i].addr;
         req_wdata      = vt[i].wdata;
         req_valid      = 1'b1;
         step();
         req_valid = 1'b0;
         chk($sformatf("v%0d.mem_valid", i),   {31'd0, mem_valid},   {31'd0, vt[i].fwd});
         chk($sformatf("v%0d.fault_pulse", i), {31'd0, fault_pulse}, {31'd0, ~vt[i].fwd});
         chk($sformatf("v%0d.req_ready", i),   {31'd0, req_ready},   32'd0);
         if (vt[i].fwd) begin
            chk($sformatf("v%0d.mem_write", i), {31'd0, mem_write}, {31'd0, vt[i].wr});
            chk($sformatf("v%0d.mem_addr", i),  mem_addr,            vt[i].addr);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata,           vt[i].wdata);
         end else begin
            model_block(vt[i].addr, 1'b0);
         end
         step();
         chk($sformatf("v%0d.idle_ready", i), {31'd0, req_ready},   32'd1);
         chk($sformatf("v%0d.idle_mv", i),    {31'd0, mem_valid},   32'd0);
         chk($sformatf("v%0d.idle_fp", i),    {31'd0, fault_pulse}, 32'd0);
         chk_fault_state($sformatf("v%0d", i));
      end

      // ---- back-to-back: one request every 2 cycles
      protected_flag = 1'b0; req_write = 1'b1; req_addr = 32'h100;
      req_wdata = 32'h55; req_valid = 1'b1; mem_ready = 1'b1;
      step();
      chk("b2b.mv1", {31'd0, mem_valid}, 32'd1);
      step();
      chk("b2b.gap", {31'd0, mem_valid}, 32'd0);
      chk("b2b.rdy", {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      chk("b2b.mv2", {31'd0, mem_valid}, 32'd1);
      step();
      chk("b2b.end", {31'd0, mem_valid}, 32'd0);

      // ---- stall in FWD: outputs hold, lock changes ignored
      protected_flag = 1'b1; protected_addr = 32'd3; req_write = 1'b1;
      req_addr = 32'h40; req_wdata = 32'hAAAA_5555; mem_ready = 1'b0;
      req_valid = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stall%0d.mv", i),    {31'd0, mem_valid}, 32'd1);
         chk($sformatf("stall%0d.mw", i),    {31'd0, mem_write}, 32'd1);
         chk($sformatf("stall%0d.addr", i),  mem_addr,           32'h40);
         chk($sformatf("stall%0d.wdata", i), mem_wdata,          32'hAAAA_5555);
         chk($sformatf("stall%0d.rdy", i),   {31'd0, req_ready}, 32'd0);
         protected_flag = ~protected_flag;
         protected_addr = 32'hFFFF_FFFF;
         req_addr       = 32'h99;
         step();
      end
      chk("stall.final_addr", mem_addr, 32'h40);
      req_valid = 1'b0; mem_ready = 1'b1;
      step();
      chk("stall.done_mv", {31'd0, mem_valid}, 32'd0);
      chk_fault_state("stall");

      // ---- fault_clear coincident with a BLOCK on address 0
      protected_flag = 1'b1; protected_addr = 32'd3; req_write = 1'b1;
      req_addr = 32'd0; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("clrblk.pulse", {31'd0, fault_pulse}, 32'd1);
      chk("clrblk.mv",    {31'd0, mem_valid},   32'd0);
      fault_clear = 1'b1;
      model_block(32'd0, 1'b1);
      step();
      fault_clear = 1'b0;
      chk_fault_state("clrblk");

      // ---- fault_clear alone: count kept
      fault_clear = 1'b1;
      fault_m = 1'b0; faddr_m = '0;
      step();
      fault_clear = 1'b0;
      chk_fault_state("clr");

      // ---- first violation after a clear is captured
      req_addr = 32'd1; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      model_block(32'd1, 1'b0);
      step();
      chk_fault_state("recap");

      // ---- reset while a request is pending in FWD
      protected_flag = 1'b0; req_addr = 32'h77; mem_ready = 1'b0;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("rstfwd.mv_before", {31'd0, mem_valid}, 32'd1);
      nreset = 1'b0;
      step();
      fault_m = 1'b0; faddr_m = '0; cnt_m = 0; cnt2_m = 0;
      chk("rstfwd.mv",    {31'd0, mem_valid},   32'd0);
      chk("rstfwd.rdy",   {31'd0, req_ready},   32'd1);
      chk("rstfwd.addr",  mem_addr,             32'd0);
      chk("rstfwd.pulse", {31'd0, fault_pulse}, 32'd0);
      chk_fault_state("rstfwd");
      nreset = 1'b1; mem_ready = 1'b1;
      step();
      chk("rstfwd.discard", {31'd0, mem_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
